// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide into HI/LO with stall and abort.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             abortE,
  input  logic             rdhiloE,
  input  logic             mthiE,
  input  logic             mtloE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stallmd
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     opd_q, opd_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic                 sa, sb, ge;
  logic [WIDTH-1:0]     amag, bmag, quot, remw;
  logic [WIDTH:0]       msum, shl, sub;
  logic [2*WIDTH-1:0]   prod;
  always_comb begin
    sa      = ~opE[0] & srcaE[WIDTH-1];
    sb      = ~opE[0] & srcbE[WIDTH-1];
    amag    = sa ? -srcaE : srcaE;
    bmag    = sb ? -srcbE : srcbE;
    msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
    shl     = {rem_q, acc_q[WIDTH-1]};
    ge      = shl >= {1'b0, opd_q};
    sub     = shl - {1'b0, opd_q};
    prod    = neg_q ? -acc_q : acc_q;
    quot    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remw    = rneg_q ? -rem_q : rem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    opd_d   = opd_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      hi_d = mthiE ? srcaE : hi_q;
      lo_d = mtloE ? srcaE : lo_q;
      if (startE && !abortE) begin
        state_d = RUN;
        cnt_d   = '0;
        div_d   = opE[1];
        neg_d   = sa ^ sb;
        rneg_d  = sa;
        dz_d    = opE[1] & ~|srcbE;
        opd_d   = opE[1] ? bmag : amag;
        acc_d   = {{WIDTH{1'b0}}, (opE[1] ? amag : bmag)};
        rem_d   = '0;
      end
    end else if (abortE) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      cnt_d   = cnt_q + 1'b1;
      acc_d   = div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge} : {msum, acc_q[WIDTH-1:1]};
      rem_d   = div_q ? (ge ? sub[WIDTH-1:0] : shl[WIDTH-1:0]) : rem_q;
      state_d = (cnt_q == CNTW'(WIDTH - 1)) ? FIX : RUN;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      hi_d    = div_q ? remw : prod[2*WIDTH-1:WIDTH];
      lo_d    = div_q ? (dz_q ? {WIDTH{1'b1}} : quot) : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opd_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opd_q   <= opd_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign stallmd = busy & (startE | rdhiloE | mthiE | mtloE);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit against hand-computed HI/LO results.
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b0, startE = 1'b0, abortE = 1'b0;
  logic        rdhiloE = 1'b0, mthiE = 1'b0, mtloE = 1'b0;
  logic [1:0]  opE = 2'b00;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic [31:0] hi, lo;
  logic        busy, done, stallmd;
  int          errors = 0, checks = 0, n = 0, pulses = 0;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .abortE(abortE), .rdhiloE(rdhiloE), .mthiE(mthiE), .mtloE(mtloE),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stallmd(stallmd)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    opE = op; srcaE = a; srcbE = b; startE = 1'b1;
    tick();
    startE = 1'b0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask
  initial begin
    tick(); tick();
    reset = 1'b1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    start_op(2'b00, 32'hFFFFFFFD, 32'd5);
    chk("mult_busy", {31'b0, busy}, 32'h1);
    wait_done(n);
    chk("mult_lat", n, 32'd33);
    chk("mult_busy_done", {31'b0, busy}, 32'h0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    tick();
    chk("done_pulse", {31'b0, done}, 32'h0);
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    chk("multu_lat", n, 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    opE = 2'b10; srcaE = 32'hFFFFFFF9; srcbE = 32'd2; startE = 1'b1;
    #1;
    chk("b2b_stall", {31'b0, stallmd}, 32'h0);
    tick();
    startE = 1'b0;
    wait_done(n);
    chk("div_lat", n, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    start_op(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(n);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'h00000001);
    start_op(2'b11, 32'd100, 32'd0);
    wait_done(n);
    chk("divz_lat", n, 32'd33);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'd100);
    start_op(2'b10, 32'hFFFFFF9C, 32'd0);
    wait_done(n);
    chk("sdivz_lo", lo, 32'hFFFFFFFF);
    chk("sdivz_hi", hi, 32'hFFFFFF9C);
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    start_op(2'b01, 32'd3, 32'd4);
    tick(); tick(); tick();
    rdhiloE = 1'b1;
    #1;
    chk("stall_rd", {31'b0, stallmd}, 32'h1);
    tick();
    rdhiloE = 1'b0; mthiE = 1'b1; srcaE = 32'hDEAD;
    #1;
    chk("stall_mthi", {31'b0, stallmd}, 32'h1);
    tick();
    mthiE = 1'b0;
    chk("mthi_ignored", hi, 32'h0);
    startE = 1'b1; opE = 2'b10; srcaE = 32'd5; srcbE = 32'd5;
    #1;
    chk("stall_start", {31'b0, stallmd}, 32'h1);
    tick();
    startE = 1'b0;
    chk("run_lo_hold", lo, 32'h80000000);
    wait_done(n);
    chk("stall_lat", n, 32'd27);
    chk("stall_hi", hi, 32'h0);
    chk("stall_lo", lo, 32'd12);
    tick();
    chk("start_ignored", {31'b0, busy}, 32'h0);
    mthiE = 1'b1; srcaE = 32'h1234;
    #1;
    chk("mthi_nostall", {31'b0, stallmd}, 32'h0);
    tick();
    mthiE = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    start_op(2'b00, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    abortE = 1'b1;
    tick();
    abortE = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      pulses += int'(done);
      tick();
    end
    chk("abort_nodone", pulses, 32'd0);
    chk("abort_hi", hi, 32'h1234);
    chk("abort_lo", lo, 32'd12);
    abortE = 1'b1;
    start_op(2'b00, 32'd7, 32'd9);
    abortE = 1'b0;
    chk("abort_beats_start", {31'b0, busy}, 32'h0);
    start_op(2'b00, 32'd7, 32'd9);
    wait_done(n);
    chk("after_abort_lat", n, 32'd33);
    chk("after_abort_hi", hi, 32'h0);
    chk("after_abort_lo", lo, 32'd63);
    start_op(2'b11, 32'd50, 32'd7);
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    start_op(2'b11, 32'd50, 32'd7);
    reset = 1'b1;
    chk("rst_blocks_start", {31'b0, busy}, 32'h0);
    start_op(2'b11, 32'd50, 32'd7);
    wait_done(n);
    chk("divu_lo", lo, 32'd7);
    chk("divu_hi", hi, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit, parametrised in width, for the Execute stage of the 5-stage pipeline. It implements mult, multu, div and divu into architectural HI/LO registers.
- Radix-2 shift-add multiply and restoring divide; one iteration per cycle.
- Drives a stall request to the hazard unit while busy, so dependent HI/LO reads, writes and new operations wait.
- Supports abort when Execute is flushed.

Parameters:
- WIDTH, 32, operand and HI/LO register width (even, >=4)
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- startE  input  1  launch operation in opE with srcaE/srcbE
- opE  input  2  00 mult, 01 multu, 10 div, 11 divu
- srcaE  input  WIDTH  multiplicand / dividend (rs)
- srcbE  input  WIDTH  multiplier / divisor (rt)
- abortE  input  1  cancel in-flight operation (Execute flush)
- rdhiloE  input  1  Execute instruction is mfhi/mflo
- mthiE  input  1  write srcaE to HI
- mtloE  input  1  write srcaE to LO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- stallmd  output  1  stall request to hazard unit

Behaviour:
- Reset (reset==0 at edge): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Takes effect mid-operation; the result is discarded.
- States: IDLE, RUN, FIX.
- IDLE -> RUN at an edge where startE=1 and abortE=0 (accept edge E0).
  - At E0, latch op, latch operand magnitudes (|x| for signed ops, raw for unsigned) and result sign flags; counter=0.
- RUN: one iteration per edge at E1..E_WIDTH; counter increments each edge; -> FIX when counter reaches WIDTH-1.
  - Mult: 2*WIDTH product accumulator, shift-add on multiplier LSB.
  - Div: restoring shift-subtract, remainder WIDTH+1 bits wide.
- FIX (edge E_(WIDTH+1)): apply signs and write HI/LO; done=1 for that cycle; busy=0; -> IDLE.
  - Mult: product negated if signs differ; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - Div: LO=quotient, negated if operand signs differ; HI=remainder, taking the dividend's sign.
- Latency: busy=1 for exactly WIDTH+1 cycles after E0. New hi/lo are visible in the same cycle done=1 (33 cycles after accept for WIDTH=32).
- Divide by zero (divisor==0, div or divu): LO=all ones, HI=dividend as supplied. No exception; latency unchanged.
- Signed overflow (div of MIN by -1): LO=MIN, HI=0.
- abortE=1 in RUN or FIX:
  - -> IDLE next edge; HI/LO unchanged; done stays 0.
  - Abort beats a same-cycle startE.
  - abortE in IDLE has no effect except suppressing startE.
- mthiE/mtloE when not busy: register written with srcaE at the edge. If startE is also set, the write happens and the later FIX overwrites it.
- stallmd = busy & (startE | rdhiloE | mthiE | mtloE), purely combinational.
  - While busy, startE/mthiE/mtloE are ignored; the hazard unit holds them.
  - stallmd=0 in the done cycle, so back-to-back issue is allowed then.
- hi/lo are registered outputs; they hold their old value throughout RUN.
- done is 0 in every cycle except the FIX-exit cycle.

Test Plan:
- Reset, then mult srcaE=0xFFFFFFFD (-3), srcbE=5 -> busy for 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then div -7/2 (0xFFFFFFF9, 2) issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/0 -> lo=0xFFFFFFFF, hi=100; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- During RUN, assert rdhiloE, mthiE, startE each in turn -> stallmd=1 each time, HI/LO and operation unaffected; with busy=0, mthiE srcaE=0x1234 -> hi=0x1234 next cycle, stallmd=0.
- Start mult 7x9, assert abortE at cycle 10 -> busy=0 next cycle, done never pulses, hi/lo retain prior values; a following start completes normally.
- Start divu, drive reset=0 at cycle 5 -> hi=lo=0, busy=0 after that edge; reset=0 held on a start edge -> not accepted.
